// File: rtl/irq_trap_ctrl.sv
// ============================================================================
// Module   : irq_trap_ctrl
// Brief    : Edge-captured, masked, fixed-priority interrupt sequencer with a
//            non-nesting trap handshake (req -> ack -> mret) and mcause output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_trap_ctrl #(
    parameter int                   NUM_SRC    = 8,
    parameter logic [NUM_SRC-1:0]   MASK_RESET = 8'h01,
    parameter logic [31:0]          CAUSE_BASE = 32'h80000010,
    localparam int                  ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               global_en,
    input  logic               mask_w_en,
    input  logic [NUM_SRC-1:0] mask_w_data,
    input  logic               int_ack,
    input  logic               ret,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [31:0]        int_cause,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_SRC-1:0] prev;
    logic [ID_W-1:0]    sel_id;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    win_id;
    logic               load_sel;

    assign rise     = irq_src & ~prev;
    assign eligible = pending & mask;

    // Scan from the top so the lowest eligible index is the last to win.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        clr        = '0;
        load_sel   = 1'b0;
        case (state)
            IDLE: begin
                if (global_en && (|eligible)) begin
                    load_sel   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    clr        = NUM_SRC'(1) << sel_id;
                    state_next = SERVICE;
                end else if (!global_en) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (ret) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            prev    <= '0;
            pending <= '0;
            mask    <= MASK_RESET;
            sel_id  <= '0;
        end else begin
            state   <= state_next;
            prev    <= irq_src;
            // A fresh edge outranks the acknowledge clear on the same bit.
            pending <= (pending & ~clr) | rise;
            if (mask_w_en) begin
                mask <= mask_w_data;
            end
            if (load_sel) begin
                sel_id <= win_id;
            end
        end
    end

    assign int_req   = (state == REQ);
    assign busy      = (state != IDLE);
    assign int_id    = sel_id;
    assign int_cause = CAUSE_BASE + {{(32 - ID_W){1'b0}}, sel_id};

endmodule

`default_nettype wire

// File: doc/irq_trap_ctrl.md
# irq_trap_ctrl

Interrupt sequencer that sits in front of the machine-mode CSR register file and the core's trap logic. It captures edge-triggered requests from up to `NUM_SRC` external sources, masks them, and selects one by fixed priority. It then runs the trap handshake: raise `int_req`, wait for the core to take the trap, and hold off further interrupts until `mret` (`ret`). It supplies the `mcause` value for the taken source. It never nests: at most one trap is in service at a time.

## Interface
Parameters
- `NUM_SRC`, 8: number of interrupt sources, 1..16.
- `MASK_RESET`, 8'h01: reset value of the source-enable mask, `NUM_SRC` bits.
- `CAUSE_BASE`, 32'h80000010: `int_cause` for source 0; source i reports `CAUSE_BASE + i`.

Ports
- `clock`: in, 1. Single clock; all state changes on posedge.
- `reset`: in, 1. Asynchronous, active-high.
- `irq_src`: in, NUM_SRC. Raw source levels, synchronous to `clock`.
- `global_en`: in, 1. Global interrupt enable (mstatus.MIE).
- `mask_w_en`: in, 1. Write strobe for the enable mask.
- `mask_w_data`: in, NUM_SRC. New mask value.
- `int_ack`: in, 1. Core has taken the trap this cycle (mepc/mcause committed).
- `ret`: in, 1. `mret` retired.
- `int_req`: out, 1. Trap request to the core.
- `int_id`: out, clog2(NUM_SRC) (min 1). Selected source index.
- `int_cause`: out, 32. `CAUSE_BASE + int_id`.
- `pending`: out, NUM_SRC. Latched pending bits, readable as mip.
- `mask`: out, NUM_SRC. Current enable mask, readable as mie.
- `busy`: out, 1. High in REQ and SERVICE.

## Operation
- Edge capture: `prev` register samples `irq_src` every cycle. `rise = irq_src & ~prev`.
  - `pending[i]` is set at the posedge where `rise[i]=1`.
  - `pending[i]` is cleared at the posedge where `int_ack=1` and `int_id=i` in REQ.
  - If set and clear coincide, set wins: the new edge is preserved.
- Mask: `mask <= mask_w_data` on `mask_w_en`, in any state.
- Eligible set: `E = pending & mask`. Winner is the lowest index in E (index 0 has the highest priority).
- FSM, states IDLE, REQ, SERVICE:
  - IDLE: if `global_en && |E`, latch the winner into `sel_id` and go to REQ. Otherwise stay.
  - REQ: `int_req=1`; `int_id`/`int_cause` come from `sel_id` and are frozen.
    - If `int_ack`: clear `pending[sel_id]` and go to SERVICE.
    - Else if `!global_en`: withdraw and go to IDLE. Pending is untouched and a new arbitration occurs later.
    - Mask writes and new edges do not change `sel_id` while in REQ.
  - SERVICE: `int_req=0`. On `ret`, go to IDLE. New edges still latch into pending.
- `ret` in IDLE or REQ, and `int_ack` outside REQ, are ignored.
- Simultaneous `int_ack` and `!global_en` in REQ: ack wins.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `int_req=0`, `busy=0`, `int_id=0`, `int_cause=CAUSE_BASE`, `pending=0`, `prev=0`, `mask=MASK_RESET`.
- Since `prev` resets to 0, a source already high at reset release registers one edge at the first posedge.
- Reset asserted mid-REQ or mid-SERVICE aborts immediately. Nothing survives reset.
- Latency: `irq_src` rises before posedge k. `pending` is visible after k. With `global_en` high and the source unmasked, `int_req` is high after posedge k+1, i.e. 2 cycles.
- `int_req` stays high until the cycle after the posedge that samples `int_ack` (or the withdraw).
- Back-to-back traps: `ret` at posedge m gives IDLE after m. The next `int_req` rises after m+1, giving a minimum 1 idle cycle between traps.
- Mask write at posedge j affects arbitration at posedge j+1 onward. Arbitration at posedge j uses the old mask.
- `int_cause` is combinational from `sel_id`. It is 32-bit, with no wrap because NUM_SRC ≤ 16.

## Test plan
- Single trap: NUM_SRC=8, `mask=8'h01`, `global_en=1`, pulse `irq_src[0]`.
  - Expect `int_req` 2 cycles later, `int_id=0`, `int_cause=32'h80000010`.
  - `int_ack` clears `pending[0]` and sets `busy=1`.
  - `ret` returns to IDLE with `busy=0`.
- Priority: mask=8'hFF, rise `irq_src[5]` and `irq_src[2]` in the same cycle.
  - Expect `int_id=2`, cause 0x80000012.
  - After `ret`, the second trap has `int_id=5`, cause 0x80000015, with the 1-cycle gap.
- Masking and withdraw:
  - With mask=8'h00, an edge on source 3 sets `pending=8'h08` and produces no `int_req`.
  - Writing mask=8'h08 gives `int_req` next cycle.
  - Dropping `global_en` before ack drops `int_req`, and `pending` stays 8'h08.
- No nesting: in SERVICE, an edge on source 1 sets `pending[1]` but `int_req` stays 0. It is requested after `ret`.
- Set/clear collision: a new rising edge on source 0 in the same cycle as `int_ack` for source 0 leaves `pending[0]=1`. A second trap on source 0 follows after `ret`.
- Async reset:
  - Assert `reset` mid-REQ between clock edges. Outputs go to reset values immediately with `int_req=0`.
  - With `irq_src[4]` held high through reset release, expect `pending[4]=1` after the first posedge.
